// File: rtl/imem_pkg.sv
// Shared constants and default program image for the RV32I instruction memory.
// Latency: n/a (compile-time constants and a pure function).
// Backpressure: n/a.
package imem_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          DEFAULT_DEPTH = 64;

  // Boot program: x1 = 5, x2 = 10, x3 = x1 + x2, followed by NOPs.
  function automatic logic [31:0] default_word(input logic [31:0] idx,
                                               input logic [31:0] nop);
    logic [31:0] w;
    case (idx)
      32'd0:   w = 32'h0050_0093;  // addi x1,x0,5
      32'd1:   w = 32'h00A0_0113;  // addi x2,x0,10
      32'd2:   w = 32'h0020_81B3;  // add  x3,x1,x2
      default: w = nop;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imem_addr_decode.sv
// Byte-address decoder: word index plus misaligned / out-of-range flags.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports:
//   addr          in   32         byte address
//   idx           out  log2DEPTH  word index addr[log2(DEPTH)+1:2] (not wrapped)
//   misaligned    out  1          addr[1:0] != 0
//   out_of_range  out  1          addr >= 4*DEPTH
module imem_addr_decode #(
  parameter int DEPTH = 64
) (
  input  logic [31:0]                addr,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       misaligned,
  output logic                       out_of_range
);

  localparam int IDX_W = $clog2(DEPTH);

  assign idx        = addr[IDX_W+1:2];
  assign misaligned = |addr[1:0];
  // DEPTH is a power of two, so addr >= 4*DEPTH is exactly "any bit above
  // the index field is set"; this avoids a 32-bit overflow in 4*DEPTH.
  assign out_of_range = |addr[31:IDX_W+2];

endmodule

// File: rtl/rv32i_instruction_memory.sv
// Instruction store for the RV32I single-cycle datapath.
// Latency: combinational read (zero cycles); load writes land on the rising edge.
// Backpressure: none; every fetch and every load strobe is accepted.
// Optional run-time reload is enabled by defining IMEM_LOAD_EN.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   addr           byte PC; instr is the containing word (NOP_INSTR if out of range)
//   misaligned     addr[1:0] != 0            (combinational)
//   out_of_range   addr >= 4*DEPTH           (combinational)
//   fault_sticky   registered OR of both flags since reset
//   load_en/load_addr/load_data  word write port (IMEM_LOAD_EN only)
module rv32i_instruction_memory
  import imem_pkg::*;
#(
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] instr,
  output logic        misaligned,
  output logic        out_of_range,
  output logic        fault_sticky
`ifdef IMEM_LOAD_EN
  ,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] rd_idx;
  logic [31:0]      stored_word;

  imem_addr_decode #(.DEPTH(DEPTH)) u_rd_decode (
    .addr         (addr),
    .idx          (rd_idx),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

`ifdef IMEM_LOAD_EN
  logic [IDX_W-1:0] load_idx;
  logic             load_oor;
  logic             load_misaligned_unused;  // low address bits are ignored on loads

  imem_addr_decode #(.DEPTH(DEPTH)) u_ld_decode (
    .addr         (load_addr),
    .idx          (load_idx),
    .misaligned   (load_misaligned_unused),
    .out_of_range (load_oor)
  );

  logic [31:0] mem [DEPTH];

  // Reset restores the boot image and wins over a coincident load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= default_word(32'(i), NOP_INSTR);
      end
    end else if (load_en && !load_oor) begin
      mem[load_idx] <= load_data;
    end
  end

  assign stored_word = mem[rd_idx];
`else
  // Constant ROM: the image is a pure function of the index.
  always_comb begin
    stored_word = default_word(32'(rd_idx), NOP_INSTR);
  end
`endif

  // Out-of-range fetches never alias onto a stored word.
  assign instr = out_of_range ? NOP_INSTR : stored_word;

  // Only fetch faults are captured; dropped loads are not faults.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky <= 1'b0;
    end else if (misaligned || out_of_range) begin
      fault_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv32i_instruction_memory.sv
module tb_rv32i_instruction_memory;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] instr;
  logic        misaligned;
  logic        out_of_range;
  logic        fault_sticky;
`ifdef IMEM_LOAD_EN
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain word array plus a sticky flag.
  logic [31:0] model_mem [DEPTH];
  logic        model_sticky;

  always #5 clk = ~clk;

  rv32i_instruction_memory #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .instr        (instr),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .fault_sticky (fault_sticky)
`ifdef IMEM_LOAD_EN
    ,
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    model_mem[0] = 32'h0050_0093;
    model_mem[1] = 32'h00A0_0113;
    model_mem[2] = 32'h0020_81B3;
    model_sticky = 1'b0;
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    if (a >= 4 * DEPTH) return NOP;
    return model_mem[a / 4];
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       a = $urandom;
      1:       a = 4 * $urandom_range(0, DEPTH - 1);
      2:       a = $urandom_range(0, 4 * DEPTH + 40);
      default: a = 4 * $urandom_range(DEPTH - 2, DEPTH + 2);
    endcase
    return a;
  endfunction

  task automatic check_read(input string tag, input logic [31:0] a);
    check({tag, ".instr"}, instr, model_instr(a));
    check({tag, ".mis"}, 32'(misaligned), 32'(a % 4 != 0));
    check({tag, ".oor"}, 32'(out_of_range), 32'(a >= 4 * DEPTH));
  endtask

  initial begin
    logic [31:0] a;
    logic        r;
`ifdef IMEM_LOAD_EN
    logic        le;
    logic [31:0] la;
    logic [31:0] ld;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
`endif
    rst  = 1'b1;
    addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset.sticky", 32'(fault_sticky), 32'd0);

    // Boot image, aligned fetches 5 ns apart.
    addr = 0; #1; check_read("a0", 0);
    #4; addr = 4; #1; check_read("a4", 4);
    #4; addr = 8; #1; check_read("a8", 8);
    check("boot.sticky", 32'(fault_sticky), 32'd0);

    // Misaligned fetch returns containing word and sets sticky.
    @(negedge clk);
    addr = 6; #1;
    check("a6.instr", instr, 32'h00A0_0113);
    check("a6.mis", 32'(misaligned), 32'd1);
    @(posedge clk); #1;
    check("a6.sticky", 32'(fault_sticky), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst.sticky_clr", 32'(fault_sticky), 32'd0);
    @(negedge clk);
    addr = 0;
    rst  = 1'b0;

    // Range boundary.
    addr = 4 * DEPTH; #1;
    check("a256.instr", instr, NOP);
    check("a256.oor", 32'(out_of_range), 32'd1);
    addr = 4 * DEPTH - 4; #1;
    check("a252.instr", instr, NOP);
    check("a252.oor", 32'(out_of_range), 32'd0);
    addr = 0;

`ifdef IMEM_LOAD_EN
    // Load becomes visible only after the edge.
    @(negedge clk);
    addr      = 12;
    load_en   = 1'b1;
    load_addr = 12;
    load_data = 32'hDEAD_BEEF;
    #1;
    check("ld12.before", instr, NOP);
    @(posedge clk); #1;
    check("ld12.after", instr, 32'hDEAD_BEEF);
    @(negedge clk);
    load_en = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;
    check("ld12.rst", instr, NOP);

    // Reset wins over a coincident load.
    @(negedge clk);
    addr      = 0;
    load_en   = 1'b1;
    load_addr = 0;
    load_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check("ldrst.w0", instr, 32'h0050_0093);

    // Out-of-range load is dropped (no wrap onto word 0) and is not a fault.
    @(negedge clk);
    rst       = 1'b0;
    load_addr = 1024;
    load_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("ld1024.w0", instr, 32'h0050_0093);
    check("ld1024.sticky", 32'(fault_sticky), 32'd0);
    @(negedge clk);
    load_en = 1'b0;
`endif

    // Randomized traffic against the model, starting from a clean reset.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      a    = pick_addr();
      r    = ($urandom_range(0, 24) == 0);
      addr = a;
      rst  = r;
`ifdef IMEM_LOAD_EN
      le = ($urandom_range(0, 2) == 0);
      la = pick_addr();
      ld = $urandom;
      load_en   = le;
      load_addr = la;
      load_data = ld;
`endif
      #1;
      check_read("rnd", a);
      @(posedge clk); #1;
      if (r) begin
        model_reset();
      end else begin
        if (a % 4 != 0 || a >= 4 * DEPTH) model_sticky = 1'b1;
`ifdef IMEM_LOAD_EN
        if (le && la < 4 * DEPTH) model_mem[la / 4] = ld;
`endif
      end
      check("rnd.sticky", 32'(fault_sticky), 32'(model_sticky));
      check("rnd.post", instr, model_instr(a));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rv32i_instruction_memory.md
# rv32i_instruction_memory

Word-organised instruction store for the RV32I single-cycle datapath. It takes the byte PC from the fetch stage and returns the 32-bit instruction at that address in the same cycle. It holds a fixed default program, flags misaligned and out-of-range fetches, and can optionally be reloaded at run time through a write port.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words; power of two, at least 4.
- `NOP_INSTR`, default 32'h0000_0013: word returned for out-of-range fetches (`addi x0,x0,0`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `addr`  in  32  byte fetch address (PC).
- `instr`  out  32  instruction at `addr`.
- `misaligned`  out  1  `addr[1:0] != 0` (combinational).
- `out_of_range`  out  1  `addr >= 4*DEPTH` (combinational).
- `fault_sticky`  out  1  registered; set once any fault has been seen since reset.
- `load_en`  in  1  write strobe (only when `IMEM_LOAD_EN` is defined).
- `load_addr`  in  32  byte address of the word to load (only when `IMEM_LOAD_EN` is defined).
- `load_data`  in  32  word to load (only when `IMEM_LOAD_EN` is defined).

## Operation
- Word index is `addr[log2(DEPTH)+1:2]`. Bits [1:0] are ignored for data, so a misaligned fetch returns the containing word and asserts `misaligned`.
- If `out_of_range` is set, `instr = NOP_INSTR`. The index is not wrapped.
- `misaligned` and `out_of_range` can be asserted together.
- Default image:
  - word 0 = 32'h0050_0093 (`addi x1,x0,5`)
  - word 1 = 32'h00A0_0113 (`addi x2,x0,10`)
  - word 2 = 32'h0020_81B3 (`add x3,x1,x2`)
  - all remaining words = `NOP_INSTR`
- `fault_sticky`:
  - Set on any rising edge where `misaligned | out_of_range`.
  - Cleared only by `rst`.

## Timing
- Read path is purely combinational: `instr`, `misaligned` and `out_of_range` follow `addr` with zero-cycle latency and do not depend on `clk` or `rst`.
- Reset value: `fault_sticky = 0`. With loading enabled, every word returns to the default image on the reset edge.
- `rst` takes precedence over `load_en` and over fault capture in the same cycle.
- Load write:
  - Occurs on the rising edge with `load_en = 1`.
  - The new word is visible on `instr` immediately after that edge.
  - Before the edge, reads return the old word.
- Load rules:
  - `load_addr[1:0]` are ignored.
  - Out-of-range `load_addr` is dropped and does not set `fault_sticky`.

## Configuration
- `IMEM_LOAD_EN` defined:
  - Storage is a `DEPTH`x32 register array with the load port.
  - Reset reinitialises the array to the default image.
- `IMEM_LOAD_EN` undefined:
  - Load ports are absent.
  - Storage is a constant ROM holding the default image.
  - Only `fault_sticky` is clocked.

## Structure
- Shared package `imem_pkg`:
  - `NOP_INSTR`
  - `DEFAULT_DEPTH`
  - a function `default_word(idx)` returning the default image entry
- One sub-module: `imem_addr_decode`. It converts a byte address into the word index plus the `misaligned` and `out_of_range` flags, and is shared by the read and load paths.

## Test plan
- Reset, then `addr` = 0, 4, 8 sampled 5 ns apart -> `instr` = 0050_0093, 00A0_0113, 0020_81B3; both flags 0; `fault_sticky` = 0.
- `addr = 6` -> `instr` = 00A0_0113 and `misaligned = 1`; after the next clock edge `fault_sticky = 1`; assert `rst` for one edge -> `fault_sticky = 0`.
- `addr` = 4*DEPTH (256) -> `instr` = 0000_0013 and `out_of_range = 1`. `addr` = 252 -> 0000_0013 with `out_of_range = 0`.
- `IMEM_LOAD_EN`: write 32'hDEAD_BEEF to `load_addr = 12` -> `addr = 12` reads DEAD_BEEF only after the edge; `rst` -> word 3 reads 0000_0013 again.
- `IMEM_LOAD_EN`: `load_en` together with `rst` at word 0 -> word 0 stays 0050_0093. Load to `load_addr = 1024` -> no change to memory and `fault_sticky` stays 0.
